input_sequencer: RTL and testbench

- Front end between hps_io and the pacman-family core (Gorkans).
- Decodes PS/2 keyboard events, merges both joysticks and applies the orientation remap.
- Replaces the combinational coin=start shortcut with a frame-timed sequence: coin pulse, gap, then start pulse.
- Drives the core's active-low in0/in1 vectors from registers.

---
 rtl/gorkans_input_pkg.sv | 31 +++
 rtl/ps2_key_latch.sv | 57 +++++
 rtl/input_sequencer.sv | 129 ++++++++++++
 tb/tb_input_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gorkans_input_pkg.sv
// Shared types and constants for the Gorkans input front end.
// Pure declarations; no logic, no latency, no flow control.
package gorkans_input_pkg;

  typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} seq_state_t;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;

  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  // Frame counts are clamped into the 8-bit counter range, never below one frame.
  function automatic logic [7:0] frames_load(input int frames);
    if (frames < 1) return 8'd1;
    if (frames > 255) return 8'd255;
    return frames[7:0];
  endfunction

endpackage

// File: rtl/ps2_key_latch.sv
// PS/2 event decoder holding one pressed/released latch per game key.
// Latches update one clk_sys after a toggle of ps2_key_i[64]; no backpressure, events are never stalled.
module ps2_key_latch
  import gorkans_input_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [64:0] ps2_key_i,
  output logic        key_up_o,
  output logic        key_down_o,
  output logic        key_left_o,
  output logic        key_right_o,
  output logic        key_fire_o,
  output logic        key_start1_o,
  output logic        key_start2_o
);

  logic       armed_q;
  logic       toggle_q;
  logic       evt;
  logic       rel;
  logic       ext;
  logic [7:0] code;

  // Multi-byte sequences (PrtScr/Pause) spill above bit 23 and are dropped.
  assign evt  = armed_q && (ps2_key_i[64] != toggle_q) && (ps2_key_i[63:24] == '0);
  assign rel  = (ps2_key_i[15:8] == 8'hF0);
  assign ext  = (ps2_key_i[15:8] == 8'hE0) || (ps2_key_i[23:16] == 8'hE0);
  assign code = ps2_key_i[7:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_q      <= 1'b0;
      toggle_q     <= 1'b0;
      key_up_o     <= 1'b0;
      key_down_o   <= 1'b0;
      key_left_o   <= 1'b0;
      key_right_o  <= 1'b0;
      key_fire_o   <= 1'b0;
      key_start1_o <= 1'b0;
      key_start2_o <= 1'b0;
    end else begin
      armed_q  <= 1'b1;
      toggle_q <= ps2_key_i[64];
      if (evt) begin
        if (code == SC_UP)    key_up_o    <= !rel;
        if (code == SC_DOWN)  key_down_o  <= !rel;
        if (code == SC_LEFT)  key_left_o  <= !rel;
        if (code == SC_RIGHT) key_right_o <= !rel;
        if (!ext && (code == SC_SPACE || code == SC_CTRL)) key_fire_o <= !rel;
        if (!ext && code == SC_F1) key_start1_o <= !rel;
        if (!ext && code == SC_F2) key_start2_o <= !rel;
      end
    end
  end

endmodule

// File: rtl/input_sequencer.sv
// Merges keyboard/joysticks into the core's active-low in0/in1 and sequences coin, gap, start by vblank frames.
// Outputs registered, one clk_sys after inputs or FSM state; no backpressure, extra start requests are dropped.
module input_sequencer
  import gorkans_input_pkg::*;
#(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic        busy
);

  localparam logic [7:0] COIN_LD  = frames_load(COIN_FRAMES);
  localparam logic [7:0] GAP_LD   = frames_load(GAP_FRAMES);
  localparam logic [7:0] START_LD = frames_load(START_FRAMES);

  if (COIN_FRAMES < 1 || GAP_FRAMES < 1 || START_FRAMES < 1) begin : g_bad_frames
    $error("input_sequencer: frame parameters must be at least 1");
  end

  logic k_up, k_down, k_left, k_right, k_fire, k_s1, k_s2;

  ps2_key_latch u_keys (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_key_i   (ps2_key),
    .key_up_o    (k_up),
    .key_down_o  (k_down),
    .key_left_o  (k_left),
    .key_right_o (k_right),
    .key_fire_o  (k_fire),
    .key_start1_o(k_s1),
    .key_start2_o(k_s2)
  );

  seq_state_t state_q;
  logic [7:0] cnt_q, cnt_d;
  logic       sel1_q, vblank_q, s1_q, s2_q;
  logic       m_up, m_down, m_left, m_right, m_fire, s1, s2;
  logic       eff_up, eff_down, eff_left, eff_right;
  logic       tick, s1_rise, s2_rise, cnt_last;
  logic [7:0] in0_d, in1_d;
  logic       unused_joy;

  assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

  assign m_up    = k_up    | joystick_0[JOY_U]      | joystick_1[JOY_U];
  assign m_down  = k_down  | joystick_0[JOY_D]      | joystick_1[JOY_D];
  assign m_left  = k_left  | joystick_0[JOY_L]      | joystick_1[JOY_L];
  assign m_right = k_right | joystick_0[JOY_R]      | joystick_1[JOY_R];
  assign m_fire  = k_fire  | joystick_0[JOY_FIRE]   | joystick_1[JOY_FIRE];
  assign s1      = k_s1    | joystick_0[JOY_START1] | joystick_1[JOY_START1];
  assign s2      = k_s2    | joystick_0[JOY_START2] | joystick_1[JOY_START2];

  // Horizontal cabinet: the stick is turned a quarter so each direction comes from its neighbour.
  assign eff_up    = rotate ? m_left  : m_up;
  assign eff_down  = rotate ? m_right : m_down;
  assign eff_left  = rotate ? m_down  : m_left;
  assign eff_right = rotate ? m_up    : m_right;

  assign tick     = vblank & ~vblank_q;
  assign s1_rise  = s1 & ~s1_q;
  assign s2_rise  = s2 & ~s2_q;
  assign cnt_d    = cnt_q - 8'd1;
  assign cnt_last = (cnt_q <= 8'd1);

  assign in0_d = ~{2'b00, state_q == COIN, 1'b0, eff_down, eff_right, eff_left, eff_up};
  assign in1_d = ~{1'b0, (state_q == START) && !sel1_q, (state_q == START) && sel1_q,
                   m_fire, 4'b0000};

  // Edge trackers reset high so a start held through reset needs a fresh press.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      sel1_q   <= 1'b0;
      vblank_q <= 1'b0;
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      in0      <= 8'hFF;
      in1      <= 8'hFF;
      busy     <= 1'b0;
    end else begin
      vblank_q <= vblank;
      s1_q     <= s1;
      s2_q     <= s2;
      in0      <= in0_d;
      in1      <= in1_d;
      busy     <= (state_q != IDLE);
      case (state_q)
        IDLE: if (s1_rise || s2_rise) begin
          sel1_q  <= s1_rise;
          cnt_q   <= COIN_LD;
          state_q <= COIN;
        end
        COIN: if (tick) begin
          if (cnt_last) begin
            cnt_q   <= GAP_LD;
            state_q <= GAP;
          end else cnt_q <= cnt_d;
        end
        GAP: if (tick) begin
          if (cnt_last) begin
            cnt_q   <= START_LD;
            state_q <= START;
          end else cnt_q <= cnt_d;
        end
        START: if (tick) begin
          if (cnt_last) begin
            cnt_q   <= 8'd0;
            state_q <= RELEASE;
          end else cnt_q <= cnt_d;
        end
        RELEASE: if (!s1 && !s2) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench for input_sequencer: reset, frame sequence, PS/2 decode, remap, filtering, mid-sequence reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_input_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        vblank;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  input_sequencer #(.COIN_FRAMES(4), .GAP_FRAMES(8), .START_FRAMES(4)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .rotate    (rotate),
    .vblank    (vblank),
    .in0       (in0),
    .in1       (in1),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic frame_tick();
    @(negedge clk_sys);
    vblank = 1'b1;
    cycles(2);
    vblank = 1'b0;
    cycles(3);
  endtask

  task automatic send_key(input logic [63:0] payload);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[64], payload};
    cycles(3);
  endtask

  task automatic check_io(input string name, input logic [7:0] e0, input logic [7:0] e1, input logic eb);
    vectors++;
    if ({in0, in1, busy} !== {e0, e1, eb}) begin
      miscompares++;
      $display("FAIL %s: in0=%h in1=%h busy=%b, expected in0=%h in1=%h busy=%b",
               name, in0, in1, busy, e0, e1, eb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ps2_key = '0; joystick_0 = '0; joystick_1 = '0;
    rotate = 1'b0; vblank = 1'b0;
    #23;
    check_io("reset_held", 8'hFF, 8'hFF, 1'b0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    cycles(4);
    check_io("reset_released", 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_sequence();
    logic [3:0] got, exp;
    @(negedge clk_sys);
    joystick_0[5] = 1'b1;
    cycles(3);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) frame_tick();
      got = {in0[5], in1[6], in1[5], busy};
      exp = {~(i < 4), 1'b1, ~(i >= 12 && i < 16), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL seq_frame%0d: {coin_n,st2_n,st1_n,busy}=%b expected %b", i, got, exp);
      end
    end
    joystick_0[5] = 1'b0;
    cycles(4);
    check_io("seq_released", 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_ps2_dirs();
    send_key(64'h75);
    check_io("ps2_up_press", 8'hFE, 8'hFF, 1'b0);
    send_key(64'hF075);
    check_io("ps2_up_release", 8'hFF, 8'hFF, 1'b0);
    rotate = 1'b1;
    send_key(64'h6B);
    check_io("ps2_left_rot_up", 8'hFE, 8'hFF, 1'b0);
    send_key(64'hF06B);
    rotate = 1'b0;
    cycles(2);
    check_io("ps2_left_release", 8'hFF, 8'hFF, 1'b0);
    send_key(64'hE075);
    check_io("ps2_ext_up_press", 8'hFE, 8'hFF, 1'b0);
    send_key(64'hE0F075);
    check_io("ps2_ext_up_release", 8'hFF, 8'hFF, 1'b0);
    send_key(64'h29);
    check_io("ps2_space_fire", 8'hFF, 8'hEF, 1'b0);
    send_key(64'hF029);
    check_io("ps2_space_release", 8'hFF, 8'hFF, 1'b0);
    send_key(64'hE014);
    check_io("ps2_rctrl_not_fire", 8'hFF, 8'hFF, 1'b0);
    send_key(64'hE0F014);
    rotate = 1'b1;
    joystick_1[3] = 1'b1;
    cycles(3);
    check_io("joy1_up_rot_right", 8'hFB, 8'hFF, 1'b0);
    joystick_1[3] = 1'b0;
    rotate = 1'b0;
    cycles(3);
  endtask

  task automatic test_ignore();
    send_key(64'h75);
    check_io("ign_up_press", 8'hFE, 8'hFF, 1'b0);
    send_key({40'hE01214, 24'h00F075});
    check_io("ign_prtscr", 8'hFE, 8'hFF, 1'b0);
    @(negedge clk_sys);
    ps2_key = {ps2_key[64], 64'hF075};
    cycles(4);
    check_io("ign_no_toggle", 8'hFE, 8'hFF, 1'b0);
    send_key(64'hF075);
    check_io("ign_real_release", 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, exp;
    @(negedge clk_sys);
    joystick_0[6:5] = 2'b11;
    @(negedge clk_sys);
    joystick_0[6:5] = 2'b00;
    cycles(2);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) frame_tick();
      if (i == 4) send_key(64'h06);
      got = {in0[5], in1[6], in1[5], busy};
      exp = {~(i < 4), 1'b1, ~(i >= 12 && i < 16), 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: {coin_n,st2_n,st1_n,busy}=%b expected %b", i, got, exp);
      end
    end
    send_key(64'hF006);
    cycles(2);
    check_io("b2b_released", 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      frame_tick();
      vectors++;
      if ({in0[5], busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL b2b_no_requeue%0d: coin_n=%b busy=%b expected coin_n=1 busy=0", i, in0[5], busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_sys);
    joystick_0[6] = 1'b1;
    cycles(3);
    for (int i = 0; i < 12; i++) frame_tick();
    check_io("mid_in_start2", 8'hFF, 8'hBF, 1'b1);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check_io("mid_async_reset", 8'hFF, 8'hFF, 1'b0);
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    frame_tick();
    frame_tick();
    check_io("mid_held_no_retrigger", 8'hFF, 8'hFF, 1'b0);
    joystick_0[6] = 1'b0;
    cycles(3);
    check_io("mid_released", 8'hFF, 8'hFF, 1'b0);
    joystick_0[6] = 1'b1;
    cycles(3);
    check_io("mid_repressed", 8'hDF, 8'hFF, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ps2_dirs();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
